acia_rx: RTL

Serial receive submodule for the ACIA: the receive counterpart of the ACIA serial transmitter. It recovers 8N1 async frames (1 start, 8 data LSB-first, 1 stop) from the rx pin using a mid-bit sampling rate counter. It delivers each byte with a one-cycle strobe plus a framing-error flag to the ACIA register/bus logic. Bit timing matches the transmitter: 115200 bps at 16 MHz clk by default.

---
 rtl/acia_pkg.sv | 20 ++
 rtl/acia_rx_sync.sv | 30 +++
 rtl/acia_rx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/acia_pkg.sv
// Shared ACIA types and constants: receiver state encoding, default bit timing
// (115200 bps at 16 MHz) and frame length.
package acia_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int ACIA_SCW       = 8;
  localparam int ACIA_SYM_CNT   = 139;
  localparam int ACIA_DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/acia_rx_sync.sv
// Two-flop synchroniser for the async rx pin plus a delay flop that turns the
// synchronised level into a one-cycle falling-edge pulse. Idles high.
module acia_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_serial,
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= rx_serial;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = ~sync_q & dly_q;

endmodule

// File: rtl/acia_rx.sv
// ACIA 8N1 serial receiver with mid-bit sampling. Build option RX_MAJORITY_EN
// takes each bit as the 2-of-3 vote of the samples at rcnt==2,1,0.
module acia_rx
  import acia_pkg::*;
#(
  parameter int SCW     = ACIA_SCW,
  parameter int SYM_CNT = ACIA_SYM_CNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_dat,
  output logic       rx_stb,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam logic [SCW-1:0] RC_FULL = SCW'(SYM_CNT);
  localparam logic [SCW-1:0] RC_HALF = SCW'(SYM_CNT >> 1);
  localparam logic [SCW-1:0] RC_ONE  = SCW'(1);
  localparam logic [2:0]     BC_LAST = 3'(ACIA_DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;
  logic bit_val;

  rx_state_t      state_q, state_d;
  logic [SCW-1:0] rcnt_q, rcnt_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     sr_q, sr_d;
  logic [7:0]     dat_q, dat_d;
  logic           err_q, err_d;
  logic           stb_q, stb_d;

  acia_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_serial (rx_serial),
    .rx_s      (rx_s),
    .rx_fall   (rx_fall)
  );

`ifdef RX_MAJORITY_EN
  // hist_q[1] holds rx_s from the rcnt==2 cycle, hist_q[0] from rcnt==1.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s};
  end

  assign bit_val = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    dat_d   = dat_q;
    err_d   = err_q;
    stb_d   = 1'b0;
    if (state_q != IDLE && rcnt_q != '0) rcnt_d = rcnt_q - RC_ONE;
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          rcnt_d  = RC_HALF;
        end
      end
      START: begin
        // A high start-bit sample means the edge was only a glitch.
        if (rcnt_q == '0) begin
          if (!bit_val) begin
            state_d = DATA;
            rcnt_d  = RC_FULL;
            bcnt_d  = BC_LAST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (rcnt_q == '0) begin
          sr_d   = {bit_val, sr_q[7:1]};
          rcnt_d = RC_FULL;
          if (bcnt_q == 3'd0) state_d = STOP;
          else                bcnt_d  = bcnt_q - 3'd1;
        end
      end
      STOP: begin
        if (rcnt_q == '0) begin
          dat_d   = sr_q;
          err_d   = ~bit_val;
          stb_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_dat  = dat_q;
  assign rx_err  = err_q;
  assign rx_stb  = stb_q;
  assign rx_busy = (state_q != IDLE);

endmodule
